pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 pipeline. Generates per-stage stall/bubble and condition-code-enable signals from hazard conditions, and owns a run-state FSM that flushes the pipeline after reset and freezes it on a terminal status reaching write-back. It also keeps retire and stall-cycle counters for debug/performance. It sits beside the F/D/E/M/W pipeline registers and drives their stall/bubble inputs.

## Interface
- Parameters:
- FLUSH_CYCLES, 4: cycles of forced bubbles after reset (1..15)
- Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- D_icode  in  4  icode in D register
- d_srcA  in  4  decode-stage source A (4'hF = RNONE)
- d_srcB  in  4  decode-stage source B
- E_icode  in  4  icode in E register
- E_dstM  in  4  E register dstM
- e_Cnd  in  1  execute-stage branch condition
- M_icode  in  4  icode in M register
- m_stat  in  3  memory-stage status
- W_stat  in  3  W register status
- W_icode  in  4  W register icode
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1 each  pipeline register controls
- set_cc  out  1  condition-code write enable
- halted  out  1  FSM in HALT
- cpu_stat  out  3  latched processor status
- retired  out  64  retired-instruction count
- stall_cycles  out  32  cycles with F_stall asserted in RUN

## Operation
- Encodings: SBUB=0, SAOK=1, SHLT=2, SADR=3, SINS=4; IHALT=0, INOP=1, IOPQ=6, IJXX=7, IRET=9, IMRMOVQ=5, IPOPQ=B; RNONE=F. "exc(s)" = s in {SHLT,SADR,SINS}.
- Hazard terms (combinational): loaduse = E_icode in {IMRMOVQ,IPOPQ} && E_dstM != RNONE && E_dstM in {d_srcA,d_srcB}; ret = IRET in {D_icode,E_icode,M_icode}; mispred = E_icode==IJXX && !e_Cnd.
- FSM states FLUSH, RUN, HALT; reset → FLUSH with flush counter 0.
- FLUSH: D_bubble=E_bubble=M_bubble=1, F_stall=1, D_stall=W_stall=0, set_cc=0; counter increments; counter==FLUSH_CYCLES-1 → RUN.
- RUN: F_stall=loaduse|ret; D_stall=loaduse; D_bubble=mispred|(ret&!loaduse); E_bubble=mispred|loaduse; M_bubble=exc(m_stat)|exc(W_stat); W_stall=exc(W_stat); set_cc=E_icode==IOPQ && !exc(m_stat) && !exc(W_stat). exc(W_stat) → HALT, cpu_stat<=W_stat.
- HALT: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0, set_cc=0, halted=1. Sticky until rst.
- Priority: D_stall and D_bubble never both 1 (loaduse wins); mispred with loaduse is impossible by construction, bench checks only outputs above.
- retired: +1 in RUN when W_stat==SAOK and W_stall==0; a SHLT in W does not count. 64-bit wrap.
- stall_cycles: +1 in RUN when F_stall; saturates at 32'hFFFFFFFF.
- Reset values: FSM=FLUSH, flush counter=0, cpu_stat=SAOK, retired=0, stall_cycles=0, halted=0; stage outputs take FLUSH values while rst is high.

## Timing
- All stage controls and set_cc are combinational from inputs and current state; they take effect at the next clk edge in the pipeline registers.
- State, cpu_stat, counters update on clk rising edge; halted/cpu_stat reflect HALT one cycle after exc(W_stat) is first seen.
- First RUN cycle is cycle FLUSH_CYCLES after rst deassertion.
- rst mid-run or in HALT: immediate return to FLUSH, counters cleared.

## Structure
- Shared package y86_pkg: stat and icode constants, RNONE; reused by the pipeline registers.
- One sub-module natural: pipe_hazard (pure combinational loaduse/ret/mispred detection); FSM, output muxing and counters in pipe_ctrl.

## Test plan
- Reset, FLUSH_CYCLES=4: cycles 0-3 D/E/M_bubble=1, F_stall=1; cycle 4 all zero with idle inputs (icodes INOP, stats SAOK).
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0; d_srcA=F, E_dstM=F -> no stall.
- Ret: M_icode=9 only -> F_stall=1, D_bubble=1; with loaduse also -> D_bubble=0, D_stall=1.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=E_bubble=1, F_stall=0; e_Cnd=1 -> none.
- Exception: E_icode=6, m_stat=SADR -> set_cc=0, M_bubble=1; then W_stat=SADR -> W_stall=1, next cycle halted=1, cpu_stat=3, retired frozen across 10 further cycles.
- Counters: 5 cycles W_stat=SAOK then W_stat=SHLT -> retired=5, cpu_stat=2; assert rst mid-HALT -> retired=0, halted=0, FLUSH restarts.

Source files
------------

// File: rtl/y86_pkg.sv
// Y86-64 status/icode/register constants shared by the pipeline registers and control.
package y86_pkg;

   localparam logic [2:0] SBUB = 3'd0;
   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [1:0] {
      ST_FLUSH,
      ST_RUN,
      ST_HALT
   } run_state_t;

   function automatic logic is_exc(input logic [2:0] s);
      return (s == SHLT) || (s == SADR) || (s == SINS);
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and stage-control outputs exchanged between pipe_ctrl and the pipeline registers.
interface pipe_ctrl_if;

   logic [3:0]  D_icode;
   logic [3:0]  d_srcA;
   logic [3:0]  d_srcB;
   logic [3:0]  E_icode;
   logic [3:0]  E_dstM;
   logic        e_Cnd;
   logic [3:0]  M_icode;
   logic [2:0]  m_stat;
   logic [2:0]  W_stat;
   logic [3:0]  W_icode;

   logic        F_stall;
   logic        D_stall;
   logic        D_bubble;
   logic        E_bubble;
   logic        M_bubble;
   logic        W_stall;
   logic        set_cc;
   logic        halted;
   logic [2:0]  cpu_stat;
   logic [63:0] retired;
   logic [31:0] stall_cycles;

   modport master (
      input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat, W_icode,
      output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted, cpu_stat,
             retired, stall_cycles
   );

   modport slave (
      output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat, W_icode,
      input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted, cpu_stat,
             retired, stall_cycles
   );

endinterface

// File: rtl/pipe_hazard.sv
// Combinational detection of load/use, return and branch-mispredict hazards.
module pipe_hazard (
   input  logic [3:0] i_D_icode,
   input  logic [3:0] i_d_srcA,
   input  logic [3:0] i_d_srcB,
   input  logic [3:0] i_E_icode,
   input  logic [3:0] i_E_dstM,
   input  logic       i_e_Cnd,
   input  logic [3:0] i_M_icode,
   output logic       o_loaduse,
   output logic       o_ret,
   output logic       o_mispred
);
   import y86_pkg::*;

   always_comb begin
      o_loaduse = ((i_E_icode == IMRMOVQ) || (i_E_icode == IPOPQ))
                  && (i_E_dstM != RNONE)
                  && ((i_E_dstM == i_d_srcA) || (i_E_dstM == i_d_srcB));
      o_ret     = (i_D_icode == IRET) || (i_E_icode == IRET) || (i_M_icode == IRET);
      o_mispred = (i_E_icode == IJXX) && !i_e_Cnd;
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stage stall/bubble generation, FLUSH/RUN/HALT run-state FSM,
// and retire / stall-cycle performance counters.
module pipe_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.master bus
);
   import y86_pkg::*;

   run_state_t  r_state;
   run_state_t  w_next;
   logic [3:0]  r_flush_cnt;
   logic [2:0]  r_cpu_stat;
   logic [63:0] r_retired;
   logic [31:0] r_stall_cycles;

   logic w_loaduse, w_ret, w_mispred, w_exc_m, w_exc_w;
   logic w_F_stall, w_D_stall, w_D_bubble, w_E_bubble, w_M_bubble, w_W_stall, w_set_cc;
   logic w_unused_w_icode;

   pipe_hazard u_hazard (
      .i_D_icode (bus.D_icode),
      .i_d_srcA  (bus.d_srcA),
      .i_d_srcB  (bus.d_srcB),
      .i_E_icode (bus.E_icode),
      .i_E_dstM  (bus.E_dstM),
      .i_e_Cnd   (bus.e_Cnd),
      .i_M_icode (bus.M_icode),
      .o_loaduse (w_loaduse),
      .o_ret     (w_ret),
      .o_mispred (w_mispred)
   );

   assign w_exc_m          = is_exc(bus.m_stat);
   assign w_exc_w          = is_exc(bus.W_stat);
   assign w_unused_w_icode = ^bus.W_icode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_FLUSH;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_FLUSH: if (r_flush_cnt == 4'(FLUSH_CYCLES - 1)) w_next = ST_RUN;
         ST_RUN:   if (w_exc_w) w_next = ST_HALT;
         ST_HALT:  w_next = ST_HALT;
         default:  w_next = ST_FLUSH;
      endcase
   end

   // loaduse takes priority over ret so D is never both stalled and bubbled
   always_comb begin
      w_F_stall  = 1'b0;
      w_D_stall  = 1'b0;
      w_D_bubble = 1'b0;
      w_E_bubble = 1'b0;
      w_M_bubble = 1'b0;
      w_W_stall  = 1'b0;
      w_set_cc   = 1'b0;
      unique case (r_state)
         ST_FLUSH: begin
            w_F_stall  = 1'b1;
            w_D_bubble = 1'b1;
            w_E_bubble = 1'b1;
            w_M_bubble = 1'b1;
         end
         ST_RUN: begin
            w_F_stall  = w_loaduse | w_ret;
            w_D_stall  = w_loaduse;
            w_D_bubble = w_mispred | (w_ret & ~w_loaduse);
            w_E_bubble = w_mispred | w_loaduse;
            w_M_bubble = w_exc_m | w_exc_w;
            w_W_stall  = w_exc_w;
            w_set_cc   = (bus.E_icode == IOPQ) && !w_exc_m && !w_exc_w;
         end
         ST_HALT: begin
            w_F_stall  = 1'b1;
            w_D_stall  = 1'b1;
            w_E_bubble = 1'b1;
            w_M_bubble = 1'b1;
            w_W_stall  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flush_cnt    <= '0;
         r_cpu_stat     <= SAOK;
         r_retired      <= '0;
         r_stall_cycles <= '0;
      end else begin
         if (r_state == ST_FLUSH) r_flush_cnt <= r_flush_cnt + 4'd1;
         if (r_state == ST_RUN) begin
            if (w_exc_w) r_cpu_stat <= bus.W_stat;
            if ((bus.W_stat == SAOK) && !w_W_stall) r_retired <= r_retired + 64'd1;
            if (w_F_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
         end
      end
   end

   assign bus.F_stall      = w_F_stall;
   assign bus.D_stall      = w_D_stall;
   assign bus.D_bubble     = w_D_bubble;
   assign bus.E_bubble     = w_E_bubble;
   assign bus.M_bubble     = w_M_bubble;
   assign bus.W_stall      = w_W_stall;
   assign bus.set_cc       = w_set_cc;
   assign bus.halted       = (r_state == ST_HALT);
   assign bus.cpu_stat     = r_cpu_stat;
   assign bus.retired      = r_retired;
   assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset flush, hazards, exception halt and counters.
module tb_pipe_ctrl;
   import y86_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_ctrl_if bus ();

   pipe_ctrl #(.FLUSH_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   // control vector order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
   localparam logic [5:0] CTL_FLUSH = 6'b101110;
   localparam logic [5:0] CTL_HALT  = 6'b110111;
   localparam logic [5:0] CTL_NONE  = 6'b000000;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [5:0] exp);
      chk(tag, 64'({bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble, bus.M_bubble, bus.W_stall}), 64'(exp));
   endtask

   task automatic idle();
      bus.D_icode = INOP;
      bus.d_srcA  = RNONE;
      bus.d_srcB  = RNONE;
      bus.E_icode = INOP;
      bus.E_dstM  = RNONE;
      bus.e_Cnd   = 1'b0;
      bus.M_icode = INOP;
      bus.m_stat  = SAOK;
      bus.W_stat  = SAOK;
      bus.W_icode = INOP;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk_ctl("reset_ctl", CTL_FLUSH);
      chk("reset_setcc", 64'(bus.set_cc), 64'd0);
      chk("reset_halted", 64'(bus.halted), 64'd0);
      chk("reset_cpustat", 64'(bus.cpu_stat), 64'(SAOK));
      chk("reset_retired", bus.retired, 64'd0);
      chk("reset_stalls", 64'(bus.stall_cycles), 64'd0);

      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk_ctl($sformatf("flush_cyc%0d", c), CTL_FLUSH);
         @(negedge clk);
      end
      #1;
      chk_ctl("first_run_idle", CTL_NONE);
      chk("first_run_setcc", 64'(bus.set_cc), 64'd0);
      chk("first_run_retired", bus.retired, 64'd0);

      @(negedge clk);
      bus.W_stat = SBUB;
      bus.E_icode = IMRMOVQ; bus.E_dstM = 4'd3; bus.d_srcA = 4'd3;
      #1;
      chk_ctl("loaduse", 6'b110100);
      chk("retired_after_one", bus.retired, 64'd1);

      @(negedge clk);
      bus.d_srcA = RNONE; bus.E_dstM = RNONE;
      #1;
      chk_ctl("loaduse_rnone", CTL_NONE);
      chk("stalls_one", 64'(bus.stall_cycles), 64'd1);

      @(negedge clk);
      bus.E_icode = INOP; bus.M_icode = IRET;
      #1;
      chk_ctl("ret_only", 6'b101000);

      @(negedge clk);
      bus.E_icode = IMRMOVQ; bus.E_dstM = 4'd3; bus.d_srcB = 4'd3;
      #1;
      chk_ctl("ret_loaduse", 6'b110100);

      @(negedge clk);
      idle();
      bus.W_stat = SBUB;
      bus.E_icode = IJXX; bus.e_Cnd = 1'b0;
      #1;
      chk_ctl("mispred", 6'b001100);
      chk("stalls_three", 64'(bus.stall_cycles), 64'd3);

      @(negedge clk);
      bus.e_Cnd = 1'b1;
      #1;
      chk_ctl("jxx_taken", CTL_NONE);

      @(negedge clk);
      bus.E_icode = IOPQ; bus.m_stat = SADR;
      #1;
      chk_ctl("m_exc", 6'b000010);
      chk("m_exc_setcc", 64'(bus.set_cc), 64'd0);

      @(negedge clk);
      bus.m_stat = SAOK;
      #1;
      chk("opq_setcc", 64'(bus.set_cc), 64'd1);

      @(negedge clk);
      bus.W_stat = SADR;
      #1;
      chk_ctl("w_exc", 6'b000011);
      chk("w_exc_setcc", 64'(bus.set_cc), 64'd0);
      chk("w_exc_not_yet_halted", 64'(bus.halted), 64'd0);

      @(negedge clk);
      idle();
      bus.E_icode = IOPQ;
      #1;
      chk("halted", 64'(bus.halted), 64'd1);
      chk("halt_cpustat", 64'(bus.cpu_stat), 64'(SADR));
      chk_ctl("halt_ctl", CTL_HALT);
      chk("halt_setcc", 64'(bus.set_cc), 64'd0);

      bus.M_icode = IRET;
      repeat (10) @(negedge clk);
      #1;
      chk("halt_retired_frozen", bus.retired, 64'd1);
      chk("halt_stalls_frozen", 64'(bus.stall_cycles), 64'd3);
      chk("halt_sticky", 64'(bus.halted), 64'd1);

      @(negedge clk);
      idle();
      rst = 1'b1;
      #1;
      chk("rst_halt_halted", 64'(bus.halted), 64'd0);
      chk("rst_halt_retired", bus.retired, 64'd0);
      chk("rst_halt_stalls", 64'(bus.stall_cycles), 64'd0);
      chk("rst_halt_cpustat", 64'(bus.cpu_stat), 64'(SAOK));
      chk_ctl("rst_halt_ctl", CTL_FLUSH);

      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk_ctl("rerun_idle", CTL_NONE);
      chk("flush_no_retire", bus.retired, 64'd0);

      repeat (5) @(negedge clk);
      bus.W_stat = SHLT;
      #1;
      chk("retired_five", bus.retired, 64'd5);
      chk_ctl("shlt_in_w", 6'b000011);

      @(negedge clk);
      bus.W_stat = SAOK;
      #1;
      chk("shlt_halted", 64'(bus.halted), 64'd1);
      chk("shlt_cpustat", 64'(bus.cpu_stat), 64'(SHLT));
      chk("shlt_not_counted", bus.retired, 64'd5);

      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("final_rst_retired", bus.retired, 64'd0);
      chk("final_rst_halted", 64'(bus.halted), 64'd0);
      chk_ctl("final_rst_ctl", CTL_FLUSH);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
